stn_fb_writer: RTL and testbench
================================

Name: stn_fb_writer

Overview:
- Consumes the per-`lck` pixel nibble and the raw `lck`/`llp`/`lflm` strobes produced by the DragonBall LCD interface stage.
- Brings the strobes into the system clock domain and packs successive nibbles into framebuffer words.
- Issues addressed write requests to the framebuffer arbiter over a valid/ready handshake.
- Sits between the LCD capture stage and the framebuffer/HDMI scan-out side.

Parameters:
- `WORD_W`, 16: framebuffer word width in bits; must be a multiple of 4. `NPW` = `WORD_W`/4 nibbles per word.
- `WORDS_PER_LINE`, 20: words stored per line (320 px at 1bpp).
- `LINES`, 240: lines stored per frame.
- `ADDR_W`, 13: width of `wr_addr`; must satisfy 2^`ADDR_W` >= `WORDS_PER_LINE`*`LINES`.

Ports:
- `clk`  in  1  system clock; must be >= 8x the `lck` frequency.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lck`  in  1  raw LCD pixel clock; asynchronous.
- `llp`  in  1  raw LCD line pulse; asynchronous.
- `lflm`  in  1  raw LCD first-line marker; asynchronous.
- `pix_nibble`  in  4  pixel nibble; changes only on `lck` rising edges.
- `wr_valid`  out  1  write request pending.
- `wr_ready`  in  1  arbiter accepts the request this cycle.
- `wr_addr`  out  `ADDR_W`  word address = `line_idx`*`WORDS_PER_LINE` + `word_idx`.
- `wr_data`  out  `WORD_W`  packed pixel word.
- `frame_start`  out  1  one-cycle pulse on each detected `lflm` rise.
- `ovf`  out  1  sticky: a completed word was dropped because the output was busy.
- `clip`  out  1  sticky: a completed word fell outside `WORDS_PER_LINE` x `LINES`.
- `flag_clr`  in  1  synchronous clear of `ovf` and `clip`.

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - `wr_valid`, `frame_start`, `ovf`, `clip` = 0.
  - `wr_addr`, `wr_data` = 0.
  - All synchronizer flops, edge-history flops, `line_idx`, `word_idx` and the nibble count = 0.
  - Reset mid-frame discards any partial word and any pending request; no write is issued after release until new data completes a word.
- Synchronisation:
  - `lck`, `llp` and `lflm` each pass through 2 flops, plus 1 history flop for edge detection.
  - Edges are detected in the `clk` domain: `lck` falling, `llp` rising, `lflm` rising.
- Nibble capture:
  - On a detected `lck` fall, `pix_nibble` is sampled directly. It is stable for the whole `lck`-high-to-low half period.
  - Packing is MSB first: nibble k of a word goes to bits [`WORD_W`-1-4k : `WORD_W`-4-4k].
  - When the count reaches `NPW`, the word is complete, the count returns to 0 and `word_idx` increments after the word is issued.
- Line end (`llp` rise):
  - If the count is nonzero, the partial word is completed with zero padding in the unfilled low nibbles.
  - Then `word_idx` = 0 and `line_idx` increments, saturating at `LINES`.
- Frame start (`lflm` rise):
  - Any partial word is discarded, the count is set to 0, `word_idx` = 0, `line_idx` = 0.
  - `frame_start` pulses for 1 cycle.
  - If an `llp` rise is detected in the same cycle, the flush uses the pre-reset address, then `lflm` resets the indices; `lflm` reset wins over the `llp` increment.
- Word issue (cycle after completion):
  - If `word_idx` >= `WORDS_PER_LINE` or `line_idx` >= `LINES`: the word is dropped, `clip` is set, and `word_idx` still increments (saturating at `WORDS_PER_LINE`).
  - Else if `wr_valid` = 0, or `wr_valid` = 1 and `wr_ready` = 1 this cycle: load `wr_addr`/`wr_data`, and `wr_valid` = 1.
  - Else the word is dropped and `ovf` is set.
- Handshake:
  - `wr_addr` and `wr_data` are held stable while `wr_valid` = 1 and `wr_ready` = 0.
  - `wr_valid` clears on the cycle after `wr_valid` and `wr_ready` are both high, unless a new word loads on that same cycle.
- Latency: a pin-level `lck` fall completing a word gives `wr_valid` high 4 `clk` cycles later (2 sync + 1 edge + 1 issue).
- Flags: if `flag_clr` coincides with a new set event, set wins.
- All address arithmetic is unsigned, `ADDR_W` bits wide, with no wrap; the clip check prevents any out-of-range address.

Test Plan:
- Reset then one line of 80 `lck` cycles with `pix_nibble` = 0xA, 0x5 alternating, `wr_ready` tied 1 -> 20 writes, addr 0..19, each `wr_data` = 0xA5A5; `wr_valid` first high 4 clks after the 4th `lck` fall.
- `lflm` pulse, then 3 lines of 80 nibbles -> `frame_start` one pulse; writes at addr 0..19, 20..39, 40..59; a second `lflm` restarts at addr 0.
- Line of 6 nibbles 0x1..0x6 then `llp` -> writes 0x1234 @0 and 0x5600 @1; next line starts at addr 20.
- `wr_ready` held 0 across two completed words -> first word held unchanged on the bus, second dropped, `ovf` = 1; `flag_clr` -> `ovf` = 0.
- Line of 96 nibbles -> 20 writes, last addr 19; words 21-24 dropped, `clip` = 1; a 241st line produces no writes.
- Assert `rst_n` low mid-word with 2 nibbles buffered and `wr_valid` = 1 -> all outputs 0 immediately; after release, the next 4 nibbles write to addr 0.

Source files
------------

// File: rtl/stn_fb_writer.sv
// STN framebuffer writer: synchronises the raw LCD strobes into clk, packs
// pixel nibbles MSB-first into framebuffer words and issues addressed writes
// over a valid/ready handshake. Out-of-frame words are clipped; words that
// complete while the output is still stalled are dropped and flagged.
module stn_fb_writer #(
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 20,
  parameter int LINES          = 240,
  parameter int ADDR_W         = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lck,
  input  logic              llp,
  input  logic              lflm,
  input  logic [3:0]        pix_nibble,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              frame_start,
  output logic              ovf,
  output logic              clip,
  input  logic              flag_clr
);

  localparam int NPW = WORD_W / 4;
  localparam int CW  = $clog2(NPW + 1);
  localparam int WW  = $clog2(WORDS_PER_LINE + 1);
  localparam int LW  = $clog2(LINES + 1);

  localparam logic [CW-1:0] NPW_C   = CW'(NPW);
  localparam logic [WW-1:0] WPL_C   = WW'(WORDS_PER_LINE);
  localparam logic [LW-1:0] LINES_C = LW'(LINES);

  // [0],[1] = two-flop synchroniser, [2] = edge history
  logic [2:0] lck_q, llp_q, lflm_q;
  logic       lck_fall, llp_rise, lflm_rise;

  // packing stage
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     widx_q, widx_d;
  logic [LW-1:0]     lidx_q, lidx_d;
  logic              comp_q, comp_d;
  logic [WORD_W-1:0] cdata_q, cdata_d;
  logic [WW-1:0]     cwidx_q, cwidx_d;
  logic [LW-1:0]     clidx_q, clidx_d;
  logic              fs_q;

  // issue stage
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              ovf_q, ovf_d;
  logic              clip_q, clip_d;
  logic              clip_hit, can_load, load;

  assign lck_fall  =  lck_q[2]  & ~lck_q[1];
  assign llp_rise  = ~llp_q[2]  &  llp_q[1];
  assign lflm_rise = ~lflm_q[2] &  lflm_q[1];

  // Strobe synchronisers and edge-history flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lck_q  <= '0;
      llp_q  <= '0;
      lflm_q <= '0;
    end else begin
      lck_q  <= {lck_q[1:0], lck};
      llp_q  <= {llp_q[1:0], llp};
      lflm_q <= {lflm_q[1:0], lflm};
    end
  end

  // Nibble packing, word completion and line/word index tracking.
  // The address of a completed word is captured with it, so the indices can
  // move on immediately (line end, frame start) without disturbing the issue.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    lidx_d  = lidx_q;
    comp_d  = 1'b0;
    cdata_d = cdata_q;
    cwidx_d = cwidx_q;
    clidx_d = clidx_q;

    if (lck_fall) begin
      for (int k = 0; k < NPW; k++) begin
        if (cnt_q == CW'(k)) acc_d[WORD_W-1-4*k -: 4] = pix_nibble;
      end
      cnt_d = cnt_q + 1'b1;
    end

    // full word, or partial word flushed by line end (low nibbles already 0)
    if (cnt_d == NPW_C || (llp_rise && cnt_d != '0)) begin
      comp_d  = 1'b1;
      cdata_d = acc_d;
      cwidx_d = widx_q;
      clidx_d = lidx_q;
      acc_d   = '0;
      cnt_d   = '0;
      widx_d  = (widx_q == WPL_C) ? widx_q : widx_q + 1'b1;
    end

    if (llp_rise) begin
      widx_d = '0;
      lidx_d = (lidx_q == LINES_C) ? lidx_q : lidx_q + 1'b1;
    end

    // frame start wins over the line-end increment; a flush above keeps
    // the pre-reset address it already captured
    if (lflm_rise) begin
      acc_d  = '0;
      cnt_d  = '0;
      widx_d = '0;
      lidx_d = '0;
    end
  end

  // Packing-stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      widx_q  <= '0;
      lidx_q  <= '0;
      comp_q  <= 1'b0;
      cdata_q <= '0;
      cwidx_q <= '0;
      clidx_q <= '0;
      fs_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      lidx_q  <= lidx_d;
      comp_q  <= comp_d;
      cdata_q <= cdata_d;
      cwidx_q <= cwidx_d;
      clidx_q <= clidx_d;
      fs_q    <= lflm_rise;
    end
  end

  // Issue decision: clip out-of-frame words, load when the bus is free or
  // being accepted this cycle, otherwise drop and flag overflow
  always_comb begin
    clip_hit   = comp_q & ((cwidx_q >= WPL_C) | (clidx_q >= LINES_C));
    can_load   = ~wr_valid_q | wr_ready;
    load       = comp_q & ~clip_hit & can_load;
    wr_valid_d = load | (wr_valid_q & ~wr_ready);
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (load) begin
      wr_addr_d = ADDR_W'(clidx_q) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(cwidx_q);
      wr_data_d = cdata_q;
    end
    // a set event on the same cycle as flag_clr keeps the flag set
    ovf_d  = (comp_q & ~clip_hit & ~can_load) | (ovf_q & ~flag_clr);
    clip_d = clip_hit | (clip_q & ~flag_clr);
  end

  // Issue-stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ovf_q      <= 1'b0;
      clip_q     <= 1'b0;
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ovf_q      <= ovf_d;
      clip_q     <= clip_d;
    end
  end

  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_start = fs_q;
  assign ovf         = ovf_q;
  assign clip        = clip_q;

endmodule

// File: tb/tb_stn_fb_writer.sv
// Scoreboard bench for stn_fb_writer: expected writes are queued as
// stimulus is driven and popped by a monitor on each accepted write.
module tb_stn_fb_writer;
  localparam int WORD_W = 16;
  localparam int WPL    = 20;
  localparam int LINES  = 240;
  localparam int ADDR_W = 13;

  logic clk = 1'b0, rst_n = 1'b0, lck = 1'b0, llp = 1'b0, lflm = 1'b0;
  logic [3:0] pix_nibble = 4'h0;
  logic wr_ready = 1'b1, flag_clr = 1'b0;
  logic wr_valid, frame_start, ovf, clip;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  stn_fb_writer #(.WORD_W(WORD_W), .WORDS_PER_LINE(WPL), .LINES(LINES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .lck(lck), .llp(llp), .lflm(lflm), .pix_nibble(pix_nibble),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .ovf(ovf), .clip(clip), .flag_clr(flag_clr));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int n_checks = 0, n_fail = 0, n_writes = 0, n_fs = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  // write monitor: compare every accepted write against the scoreboard
  always @(negedge clk) begin
    if (rst_n && frame_start) n_fs++;
    if (rst_n && wr_valid && wr_ready) begin
      n_writes++;
      n_checks++;
      last_addr = wr_addr;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write", wr_addr, wr_data);
      end else begin
        mon_e = sbq.pop_front();
        if ({wr_addr, wr_data} !== mon_e) begin
          n_fail++;
          $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                   wr_addr, wr_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    pix_nibble = n;
    lck = 1'b1;
    tick(4);
    lck = 1'b0;
    tick(4);
  endtask

  task automatic pulse_llp();
    llp = 1'b1;
    tick(4);
    llp = 1'b0;
    tick(4);
  endtask

  task automatic pulse_lflm();
    lflm = 1'b1;
    tick(4);
    lflm = 1'b0;
    tick(4);
  endtask

  task automatic push(input int addr, input logic [WORD_W-1:0] data);
    exp_t e;
    e.addr = ADDR_W'(addr);
    e.data = data;
    sbq.push_back(e);
  endtask

  // send n nibbles (seed + step*i); queue expected words for in-frame slots,
  // including the zero-padded partial word the following line end flushes
  task automatic send_line(input int n, input int line, input int seed, input int step);
    logic [WORD_W-1:0] w;
    logic [3:0] nb;
    int wi;
    w = '0;
    wi = 0;
    for (int i = 0; i < n; i++) begin
      nb = 4'((seed + step * i) & 15);
      w[WORD_W-1-4*(i%4) -: 4] = nb;
      if (i % 4 == 3) begin
        if (wi < WPL && line < LINES) push(line * WPL + wi, w);
        w = '0;
        wi++;
      end
      send_nib(nb);
    end
    if (n % 4 != 0 && wi < WPL && line < LINES) push(line * WPL + wi, w);
  endtask

  task automatic chk_empty(input string name);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d writes outstanding, required 0", name, sbq.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_checks++;
    if ({wr_valid, frame_start, ovf, clip, wr_addr, wr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b fs=%b ovf=%b clip=%b addr=%0d data=%h, required all 0",
               wr_valid, frame_start, ovf, clip, wr_addr, wr_data);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_first_line();
    int w0;
    w0 = n_writes;
    wr_ready = 1'b1;
    send_nib(4'hA);
    send_nib(4'h5);
    send_nib(4'hA);
    push(0, 16'hA5A5);
    pix_nibble = 4'h5;
    lck = 1'b1;
    tick(4);
    lck = 1'b0;
    tick(3);
    n_checks++;
    if (wr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got wr_valid %b 3 clks after fall, required 0", wr_valid);
    end
    tick(1);
    n_checks++;
    if (wr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_4clk: got wr_valid %b 4 clks after fall, required 1", wr_valid);
    end
    tick(3);
    for (int w = 1; w < WPL; w++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 3) push(w, 16'hA5A5);
        send_nib((k % 2 == 0) ? 4'hA : 4'h5);
      end
    end
    tick(4);
    chk_empty("line1_drain");
    n_checks++;
    if (n_writes - w0 != 20) begin
      n_fail++;
      $display("FAIL line1_count: got %0d writes, required 20", n_writes - w0);
    end
    pulse_llp();
  endtask

  task automatic test_frames();
    int w0, f0;
    w0 = n_writes;
    f0 = n_fs;
    pulse_lflm();
    n_checks++;
    if (n_fs - f0 != 1) begin
      n_fail++;
      $display("FAIL frame_start_pulse: got %0d pulse cycles, required 1", n_fs - f0);
    end
    for (int l = 0; l < 3; l++) begin
      send_line(80, l, l * 5 + 1, 3);
      pulse_llp();
    end
    tick(2);
    chk_empty("frames_drain");
    n_checks++;
    if (n_writes - w0 != 60) begin
      n_fail++;
      $display("FAIL frames_count: got %0d writes, required 60", n_writes - w0);
    end
    pulse_lflm();
    send_line(4, 0, 9, 2);
    tick(4);
    chk_empty("frame_restart");
    n_checks++;
    if (last_addr !== '0) begin
      n_fail++;
      $display("FAIL frame_restart_addr: got addr %0d, required 0", last_addr);
    end
    pulse_llp();
  endtask

  task automatic test_partial();
    pulse_lflm();
    send_line(6, 0, 1, 1);
    pulse_llp();
    tick(2);
    chk_empty("partial_flush");
    send_line(4, 1, 7, 1);
    tick(4);
    chk_empty("partial_next_line");
    n_checks++;
    if (last_addr !== ADDR_W'(20)) begin
      n_fail++;
      $display("FAIL partial_next_addr: got addr %0d, required 20", last_addr);
    end
    pulse_llp();
  endtask

  task automatic test_ovf();
    pulse_lflm();
    wr_ready = 1'b0;
    send_line(4, 0, 2, 1);
    for (int i = 0; i < 20 && !wr_valid; i++) tick(1);
    n_checks++;
    if (wr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_valid: got wr_valid %b, required 1", wr_valid);
    end
    for (int k = 0; k < 4; k++) send_nib(4'hF);
    tick(2);
    n_checks++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 13'd0, 16'h2345}) begin
      n_fail++;
      $display("FAIL ovf_hold: got v=%b addr %0d data %h, required v=1 addr 0 data 2345",
               wr_valid, wr_addr, wr_data);
    end
    n_checks++;
    if ({ovf, clip} !== 2'b10) begin
      n_fail++;
      $display("FAIL ovf_set: got ovf=%b clip=%b, required ovf=1 clip=0", ovf, clip);
    end
    wr_ready = 1'b1;
    tick(3);
    chk_empty("ovf_release");
    n_checks++;
    if (wr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_dropped: got wr_valid %b, required 0", wr_valid);
    end
    flag_clr = 1'b1;
    tick(1);
    flag_clr = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got ovf %b, required 0", ovf);
    end
    pulse_llp();
  endtask

  task automatic test_clip();
    int w0;
    pulse_lflm();
    w0 = n_writes;
    send_line(96, 0, 3, 5);
    tick(4);
    chk_empty("clip_line");
    n_checks++;
    if (n_writes - w0 != 20 || last_addr !== ADDR_W'(19)) begin
      n_fail++;
      $display("FAIL clip_count: got %0d writes last addr %0d, required 20 last addr 19",
               n_writes - w0, last_addr);
    end
    n_checks++;
    if (clip !== 1'b1) begin
      n_fail++;
      $display("FAIL clip_set: got clip %b, required 1", clip);
    end
    flag_clr = 1'b1;
    tick(1);
    flag_clr = 1'b0;
    n_checks++;
    if (clip !== 1'b0) begin
      n_fail++;
      $display("FAIL clip_clear: got clip %b, required 0", clip);
    end
    repeat (LINES) pulse_llp();
    w0 = n_writes;
    send_line(4, LINES, 1, 1);
    tick(4);
    n_checks++;
    if (n_writes != w0 || clip !== 1'b1) begin
      n_fail++;
      $display("FAIL clip_line241: got %0d writes clip %b, required 0 writes clip 1",
               n_writes - w0, clip);
    end
  endtask

  task automatic test_reset_mid();
    pulse_lflm();
    wr_ready = 1'b0;
    for (int k = 0; k < 6; k++) send_nib(4'(k + 1));
    n_checks++;
    if (wr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got wr_valid %b, required 1", wr_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wr_valid, frame_start, ovf, clip, wr_addr, wr_data} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got v=%b fs=%b ovf=%b clip=%b addr=%0d data=%h, required all 0",
               wr_valid, frame_start, ovf, clip, wr_addr, wr_data);
    end
    tick(2);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    tick(2);
    send_line(4, 0, 12, 1);
    tick(4);
    chk_empty("rstmid_after");
    n_checks++;
    if (last_addr !== '0) begin
      n_fail++;
      $display("FAIL rstmid_addr: got addr %0d, required 0", last_addr);
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_frames();
    test_partial();
    test_ovf();
    test_clip();
    test_reset_mid();
    tick(4);
    chk_empty("final_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
